// File: rtl/lynxTypes.sv
// -----------------------------------------------------------------------------
// lynxTypes
//   Shared shell types for the RDMA datapath. Holds the read/write command
//   descriptor carried on metaIntf links and the width constants that size it.
//
//   Contents:
//     LEN_BITS        width of a command length field (bytes)
//     VADDR_BITS      width of a virtual address
//     PMTU_BYTES_DEF  default path MTU used to chunk RDMA reads
//     req_t           command descriptor (vaddr, len, host, vfid and routing)
// -----------------------------------------------------------------------------
package lynxTypes;

   localparam int LEN_BITS       = 28;
   localparam int VADDR_BITS     = 48;
   localparam int PMTU_BYTES_DEF = 4096;

   localparam int OPCODE_BITS = 5;
   localparam int STRM_BITS   = 2;
   localparam int VFID_BITS   = 4;
   localparam int PID_BITS    = 6;
   localparam int DEST_BITS   = 4;

   typedef struct packed {
      logic [OPCODE_BITS-1:0] opcode;
      logic [STRM_BITS-1:0]   strm;
      logic                   mode;
      logic                   rdma;
      logic                   remote;
      logic [VFID_BITS-1:0]   vfid;
      logic [PID_BITS-1:0]    pid;
      logic [DEST_BITS-1:0]   dest;
      logic                   last;
      logic [VADDR_BITS-1:0]  vaddr;
      logic [LEN_BITS-1:0]    len;
      logic                   host;
   } req_t;

endpackage : lynxTypes

// File: rtl/metaIntf.sv
// -----------------------------------------------------------------------------
// metaIntf
//   Valid/ready link carrying one req_t descriptor per handshake. A transfer
//   happens on a rising clock edge where valid and ready are both 1.
//
//   Signals:
//     valid  source has a descriptor on data
//     ready  sink accepts the descriptor this cycle
//     data   req_t descriptor
//   Modports:
//     m  source side (drives valid/data)
//     s  sink side   (drives ready)
// -----------------------------------------------------------------------------
interface metaIntf;
   import lynxTypes::*;

   logic valid;
   logic ready;
   req_t data;

   modport m (output valid, output data, input ready);
   modport s (input valid, input data, output ready);

endinterface : metaIntf

// File: rtl/rdma_req_split.sv
// -----------------------------------------------------------------------------
// rdma_req_split
//   Splits an RDMA read command into PMTU-sized chunks. Chunk k carries
//   vaddr0 + k*PMTU_BYTES and min(remaining, PMTU_BYTES); all other fields are
//   copied unchanged. A zero-length command yields one zero-length chunk.
//   One command is held at a time; chunk 0 appears the cycle after the
//   command is accepted and further chunks follow one per cycle while m_req is
//   ready. A new command can load in the cycle the final chunk leaves, so
//   back-to-back commands run without a bubble.
//
//   Parameters:
//     PMTU_BYTES  chunk size in bytes (power of two, 64 .. 2^(LEN_BITS-1))
//     N_PEND      reserved; the block always holds a single command
//
//   Ports:
//     aclk            clock
//     aresetn         asynchronous active-low reset
//     s_req           incoming command (metaIntf sink)
//     m_req           chunked command  (metaIntf source)
//     stat_req_cnt    accepted s_req commands   (RDMA_SPLIT_STATS_EN only)
//     stat_chunk_cnt  m_req handshakes          (RDMA_SPLIT_STATS_EN only)
//
//   Build option:
//     RDMA_SPLIT_STATS_EN  adds the two free-running 32-bit statistic counters
// -----------------------------------------------------------------------------
module rdma_req_split
   import lynxTypes::*;
#(
   parameter int PMTU_BYTES = PMTU_BYTES_DEF,
   parameter int N_PEND     = 1
) (
   input  logic        aclk,
   input  logic        aresetn,
   metaIntf.s          s_req,
   metaIntf.m          m_req
`ifdef RDMA_SPLIT_STATS_EN
   ,
   output logic [31:0] stat_req_cnt,
   output logic [31:0] stat_chunk_cnt
`endif
);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SPLIT = 1'b1
   } state_t;

   localparam logic [LEN_BITS-1:0]   PMTU_LEN = LEN_BITS'(PMTU_BYTES);
   localparam logic [VADDR_BITS-1:0] PMTU_VA  = VADDR_BITS'(PMTU_BYTES);

   // N_PEND is kept for interface compatibility; the block holds a single
   // command for any value.
   generate
      if (N_PEND != 1) begin : g_n_pend_reserved
      end
   endgenerate

   state_t              state_reg;
   logic                m_valid_reg;
   logic                s_ready_en_reg;
   req_t                out_reg;
   logic [LEN_BITS-1:0] rem_reg;

   logic                final_chunk;
   logic                m_hs;
   logic                s_ready;
   logic                s_hs;
   logic [LEN_BITS-1:0] rem_next;

   function automatic logic [LEN_BITS-1:0] chunk_len(input logic [LEN_BITS-1:0] rem);
      return (rem < PMTU_LEN) ? rem : PMTU_LEN;
   endfunction

   // The exact-multiple case (rem == PMTU) must be final, otherwise a
   // zero-length trailing chunk would be produced.
   assign final_chunk = (rem_reg <= PMTU_LEN);
   assign m_hs        = m_valid_reg & m_req.ready;
   assign rem_next    = rem_reg - PMTU_LEN;

   // s_ready_en_reg keeps ready low during reset and until the first edge
   // after release. In ST_SPLIT the slot only frees when the final chunk
   // leaves this cycle, which is why ready follows m_req.ready here.
   always_comb begin
      s_ready = 1'b0;
      if (s_ready_en_reg) begin
         if (state_reg == ST_IDLE) begin
            s_ready = 1'b1;
         end else begin
            s_ready = m_hs & final_chunk;
         end
      end
   end

   assign s_hs = s_ready & s_req.valid;

   // Control FSM: state and registered valid.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_reg      <= ST_IDLE;
         m_valid_reg    <= 1'b0;
         s_ready_en_reg <= 1'b0;
      end else begin
         s_ready_en_reg <= 1'b1;
         case (state_reg)
            ST_IDLE: begin
               if (s_hs) begin
                  state_reg   <= ST_SPLIT;
                  m_valid_reg <= 1'b1;
               end
            end
            ST_SPLIT: begin
               // A reload in the same cycle keeps the FSM in ST_SPLIT.
               if (m_hs && final_chunk && !s_hs) begin
                  state_reg   <= ST_IDLE;
                  m_valid_reg <= 1'b0;
               end
            end
            default: begin
               state_reg   <= ST_IDLE;
               m_valid_reg <= 1'b0;
            end
         endcase
      end
   end

   // Output register and remaining counter. Contents are don't-care while
   // m_req.valid is low, so they carry no reset.
   always_ff @(posedge aclk) begin
      if (s_hs) begin
         out_reg     <= s_req.data;
         out_reg.len <= chunk_len(s_req.data.len);
         rem_reg     <= s_req.data.len;
      end else if (m_hs && !final_chunk) begin
         out_reg.vaddr <= out_reg.vaddr + PMTU_VA;
         out_reg.len   <= chunk_len(rem_next);
         rem_reg       <= rem_next;
      end
   end

   assign m_req.valid = m_valid_reg;
   assign m_req.data  = out_reg;
   assign s_req.ready = s_ready;

`ifdef RDMA_SPLIT_STATS_EN
   logic [31:0] req_cnt_reg;
   logic [31:0] chunk_cnt_reg;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         req_cnt_reg   <= '0;
         chunk_cnt_reg <= '0;
      end else begin
         if (s_hs) begin
            req_cnt_reg <= req_cnt_reg + 32'd1;
         end
         if (m_hs) begin
            chunk_cnt_reg <= chunk_cnt_reg + 32'd1;
         end
      end
   end

   assign stat_req_cnt   = req_cnt_reg;
   assign stat_chunk_cnt = chunk_cnt_reg;
`endif

endmodule : rdma_req_split

// File: tb/tb_rdma_req_split.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_rdma_req_split
//   Scoreboard bench: each accepted command is expanded by a plain arithmetic
//   model into its expected chunks; a monitor pops and compares every m_req
//   handshake and checks that stalled data holds.
// -----------------------------------------------------------------------------
module tb_rdma_req_split;
   import lynxTypes::*;

   localparam int P = PMTU_BYTES_DEF;

   logic aclk    = 1'b0;
   logic aresetn = 1'b0;
   always #5 aclk = ~aclk;

   metaIntf s_if ();
   metaIntf m_if ();

`ifdef RDMA_SPLIT_STATS_EN
   logic [31:0] stat_req_cnt;
   logic [31:0] stat_chunk_cnt;
`endif

   rdma_req_split #(
      .PMTU_BYTES (P),
      .N_PEND     (1)
   ) dut (
      .aclk           (aclk),
      .aresetn        (aresetn),
      .s_req          (s_if),
      .m_req          (m_if)
`ifdef RDMA_SPLIT_STATS_EN
      ,
      .stat_req_cnt   (stat_req_cnt),
      .stat_chunk_cnt (stat_chunk_cnt)
`endif
   );

   int   n_cmp = 0;
   int   n_err = 0;
   req_t exp_q[$];
   int   hs_cyc[$];
   int   cyc = 0;
   int   ready_mode = 0;      // 0: always 1, 1: random 50%, 2: ready_force
   logic ready_force = 1'b0;
   int   last_s_cyc = 0;
   int   n_acc = 0;
   int   n_chunks = 0;

   always @(posedge aclk) cyc <= cyc + 1;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endfunction

   function automatic void chk_req(string name, req_t act, req_t exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got vaddr=%h len=%0d raw=%h, required vaddr=%h len=%0d raw=%h",
                  name, act.vaddr, act.len, act, exp.vaddr, exp.len, exp);
      end
   endfunction

   // Reference: ceil(len/P) chunks (one for len 0), chunk k at vaddr+k*P
   // carrying min(len-k*P, P) bytes; every other field copied.
   function automatic void model_push(req_t r);
      longint unsigned l = longint'(r.len);
      longint unsigned n = (l == 0) ? 1 : (l + P - 1) / P;
      for (longint unsigned k = 0; k < n; k++) begin
         req_t            c   = r;
         longint unsigned rem = l - k * P;
         c.vaddr = r.vaddr + VADDR_BITS'(k * P);
         c.len   = LEN_BITS'((rem < P) ? rem : P);
         exp_q.push_back(c);
      end
   endfunction

   function automatic req_t mk_req(logic [VADDR_BITS-1:0] va, logic [LEN_BITS-1:0] ln);
      req_t r = '0;
      r.opcode = OPCODE_BITS'($urandom);
      r.strm   = STRM_BITS'($urandom);
      r.mode   = 1'($urandom);
      r.rdma   = 1'($urandom);
      r.remote = 1'($urandom);
      r.vfid   = VFID_BITS'($urandom);
      r.pid    = PID_BITS'($urandom);
      r.dest   = DEST_BITS'($urandom);
      r.last   = 1'($urandom);
      r.host   = 1'($urandom);
      r.vaddr  = va;
      r.len    = ln;
      return r;
   endfunction

   // m_req.ready driver, updated 2 ns after each rising edge.
   initial begin
      m_if.ready = 1'b0;
      forever begin
         @(posedge aclk);
         #2;
         case (ready_mode)
            0:       m_if.ready = 1'b1;
            1:       m_if.ready = 1'($urandom_range(0, 1));
            default: m_if.ready = ready_force;
         endcase
      end
   end

   // Monitor: compare every chunk handshake and hold-while-stalled.
   initial begin : monitor
      req_t held;
      req_t e;
      bit   stalled;
      stalled = 1'b0;
      forever begin
         @(negedge aclk);
         if (!aresetn || m_if.valid !== 1'b1) begin
            stalled = 1'b0;
         end else begin
            if (stalled) chk_req("stall_stable", m_if.data, held);
            if (m_if.ready) begin
               stalled = 1'b0;
               n_chunks++;
               hs_cyc.push_back(cyc);
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected_chunk: got vaddr=%h len=%0d, required no chunk",
                           m_if.data.vaddr, m_if.data.len);
               end else begin
                  e = exp_q.pop_front();
                  chk_req("chunk", m_if.data, e);
               end
            end else begin
               held    = m_if.data;
               stalled = 1'b1;
            end
         end
      end
   end

   // Present r from posedge+1; returns at posedge+1 after the handshake edge
   // with valid still high so a following send is back-to-back.
   task automatic send(input req_t r);
      int waited = 0;
      s_if.valid = 1'b1;
      s_if.data  = r;
      @(negedge aclk);
      while (s_if.ready !== 1'b1 && waited < 300) begin
         waited++;
         @(negedge aclk);
      end
      if (s_if.ready !== 1'b1) begin
         n_cmp++;
         n_err++;
         $display("FAIL accept_timeout: got s_req.ready=%b, required 1", s_if.ready);
         s_if.valid = 1'b0;
      end else begin
         model_push(r);
         last_s_cyc = cyc;
         n_acc++;
      end
      @(posedge aclk);
      #1;
   endtask

   task automatic drain();
      int w = 0;
      while ((exp_q.size() != 0 || m_if.valid === 1'b1) && w < 3000) begin
         @(negedge aclk);
         w++;
      end
      chk("drain_pending", exp_q.size(), 0);
      @(posedge aclk);
      #1;
   endtask

   task automatic check_burst(string name, int n_exp, int s_cyc);
      chk({name, "_count"}, hs_cyc.size(), n_exp);
      if (hs_cyc.size() > 0) chk({name, "_latency"}, hs_cyc[0], s_cyc + 1);
      for (int i = 1; i < hs_cyc.size(); i++) chk({name, "_gap"}, hs_cyc[i] - hs_cyc[i-1], 1);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got no end of run, required finish within time budget");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int s0;
      logic [VADDR_BITS-1:0] va;
      logic [LEN_BITS-1:0]   ln;
      s_if.valid = 1'b0;
      s_if.data  = '0;

      // Reset behaviour and ready release timing.
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      chk("rst_m_valid", m_if.valid, 0);
      chk("rst_s_ready", s_if.ready, 0);
`ifdef RDMA_SPLIT_STATS_EN
      chk("rst_stat_req", stat_req_cnt, 0);
      chk("rst_stat_chunk", stat_chunk_cnt, 0);
`endif
      aresetn = 1'b1;
      #1;
      chk("ready_before_edge", s_if.ready, 0);
      @(posedge aclk);
      #1;
      chk("ready_after_edge", s_if.ready, 1);
      chk("idle_m_valid", m_if.valid, 0);

      // len 10000 at 0x1000 -> 3 chunks on consecutive cycles.
      hs_cyc.delete();
      send(mk_req(48'h1000, 28'd10000));
      s_if.valid = 1'b0;
      s0 = last_s_cyc;
      drain();
      check_burst("len10000", 3, s0);

      // Exact multiple: two full chunks, no zero-length tail.
      hs_cyc.delete();
      send(mk_req(48'h0000_1234_5000, 28'(2 * P)));
      s_if.valid = 1'b0;
      s0 = last_s_cyc;
      drain();
      check_burst("len8192", 2, s0);
`ifdef RDMA_SPLIT_STATS_EN
      chk("stat_req_after_two", stat_req_cnt, 2);
      chk("stat_chunk_after_two", stat_chunk_cnt, 5);
`endif

      // len 0 then len 64 back-to-back with no bubble.
      hs_cyc.delete();
      send(mk_req(48'h0000_0000_8000, 28'd0));
      s0 = last_s_cyc;
      send(mk_req(48'h0000_0000_9040, 28'd64));
      s_if.valid = 1'b0;
      chk("b2b_accept_gap", last_s_cyc - s0, 1);
      drain();
      check_burst("len0_len64", 2, s0);

      // Randomised commands with 50% m_req.ready.
      ready_mode = 1;
      for (int i = 0; i < 80; i++) begin
         case ($urandom_range(0, 4))
            0:       ln = '0;
            1:       ln = LEN_BITS'($urandom_range(1, P));
            2:       ln = LEN_BITS'(P * $urandom_range(1, 4));
            3:       ln = LEN_BITS'($urandom_range(1, 5 * P));
            default: ln = LEN_BITS'(P * $urandom_range(1, 3) + $urandom_range(0, 2) - 1);
         endcase
         if ($urandom_range(0, 7) == 0) va = 48'hFFFF_FFFF_E000 + VADDR_BITS'($urandom_range(0, 4095));
         else                           va = {16'($urandom), 32'($urandom)};
         send(mk_req(va, ln));
         if ($urandom_range(0, 2) == 0) begin
            s_if.valid = 1'b0;
            repeat ($urandom_range(1, 3)) begin
               @(posedge aclk);
               #1;
            end
         end
      end
      s_if.valid = 1'b0;
      drain();

      // Reset after the first of three chunks discards the rest.
      ready_force = 1'b0;
      ready_mode  = 2;
      @(posedge aclk);
      #1;
      send(mk_req(48'h0000_00A0_0000, 28'(3 * P)));
      s_if.valid  = 1'b0;
      ready_force = 1'b1;
      @(posedge aclk);
      #1;
      ready_force = 1'b0;
      #2;
      aresetn = 1'b0;
      #1;
      chk("midrst_m_valid", m_if.valid, 0);
      chk("midrst_s_ready", s_if.ready, 0);
      chk("midrst_pending", exp_q.size(), 2);
      exp_q.delete();
      n_acc    = 0;
      n_chunks = 0;
`ifdef RDMA_SPLIT_STATS_EN
      chk("midrst_stat_req", stat_req_cnt, 0);
`endif
      repeat (2) @(negedge aclk);
      aresetn = 1'b1;
      @(posedge aclk);
      #1;
      chk("post_rst_s_ready", s_if.ready, 1);
      ready_mode = 0;
      repeat (10) @(posedge aclk);
      #1;
      chk("post_rst_no_stale", m_if.valid, 0);

      // Block still works after the reset.
      hs_cyc.delete();
      send(mk_req(48'h0000_0000_3000, 28'd5000));
      s_if.valid = 1'b0;
      s0 = last_s_cyc;
      drain();
      check_burst("post_rst_len5000", 2, s0);
`ifdef RDMA_SPLIT_STATS_EN
      chk("stat_req_final", stat_req_cnt, 32'(n_acc));
      chk("stat_chunk_final", stat_chunk_cnt, 32'(n_chunks));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_rdma_req_split
